// File: rtl/imm_pkg.sv
// Shared definitions for the immediate encoder and the extend decoder:
// immediate-source mode codes, encoder state enum and the direct-mode encode helper.
package imm_pkg;

    localparam logic [1:0] IMM_DP8   = 2'b00;
    localparam logic [1:0] IMM_MEM12 = 2'b01;
    localparam logic [1:0] IMM_BR24  = 2'b10;
    localparam logic [1:0] IMM_ROT   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic        ok;
        logic [23:0] field;
    } imm_res_t;

    // Single-cycle encoding for the non-rotated modes; field stays 0 when not encodable.
    function automatic imm_res_t encode_direct(input logic [1:0] mode, input logic [31:0] value);
        imm_res_t res;
        res = '0;
        case (mode)
            IMM_DP8: begin
                if (value[31:8] == 24'd0) begin
                    res.ok    = 1'b1;
                    res.field = {16'd0, value[7:0]};
                end
            end
            IMM_MEM12: begin
                if (value[31:12] == 20'd0) begin
                    res.ok    = 1'b1;
                    res.field = {12'd0, value[11:0]};
                end
            end
            IMM_BR24: begin
                if (value[1:0] == 2'b00 && value[31:26] == {6{value[25]}}) begin
                    res.ok    = 1'b1;
                    res.field = value[25:2];
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/imm_rot_check.sv
// Tests one rotation of the rotated-immediate search: rotates value left by 2*rot
// and reports whether the result fits in eight bits.
module imm_rot_check (
    input  logic [31:0] value,
    input  logic [3:0]  rot,
    output logic        hit,
    output logic [7:0]  imm8
);

    logic [5:0]  sh;
    logic [31:0] cand;

    // A shift by 32 yields 0, so rot 0 needs no special case.
    always_comb begin
        sh   = {1'b0, rot, 1'b0};
        cand = (value << sh) | (value >> (6'd32 - sh));
    end

    assign hit  = (cand[31:8] == 24'd0);
    assign imm8 = cand[7:0];

endmodule

// File: rtl/imm_encoder.sv
// Immediate-field encoder: inverse of extend, with a one-rotation-per-cycle
// search for the rotated data-processing immediate.
//
// state     | meaning
// ST_IDLE   | waiting for a request, in_ready high
// ST_SEARCH | rotated mode, testing rotation rot_q this cycle
// ST_RESP   | result held on ok/field until out_ready
module imm_encoder
    import imm_pkg::*;
#(
    parameter int MAX_ROT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  mode,
    input  logic [31:0] value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        ok,
    output logic [23:0] field
);

    state_e      state_q, state_d;
    logic [31:0] value_q, value_d;
    logic [3:0]  rot_q, rot_d;
    logic        ok_q, ok_d;
    logic [23:0] field_q, field_d;
    logic        out_valid_q, out_valid_d;

    logic        rot_hit;
    logic [7:0]  rot_imm8;
    imm_res_t    direct_res;

    imm_rot_check u_rot_check (
        .value (value_q),
        .rot   (rot_q),
        .hit   (rot_hit),
        .imm8  (rot_imm8)
    );

    assign direct_res = encode_direct(mode, value);

    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        rot_d       = rot_q;
        ok_d        = ok_q;
        field_d     = field_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    value_d = value;
                    if (mode == IMM_ROT) begin
                        rot_d   = 4'd0;
                        state_d = ST_SEARCH;
                    end else begin
                        ok_d        = direct_res.ok;
                        field_d     = direct_res.field;
                        out_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_SEARCH: begin
                if (rot_hit) begin
                    ok_d        = 1'b1;
                    field_d     = {12'd0, rot_q, rot_imm8};
                    out_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (rot_q == 4'(MAX_ROT)) begin
                    ok_d        = 1'b0;
                    field_d     = 24'd0;
                    out_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    rot_d = rot_q + 4'd1;
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            value_q     <= 32'd0;
            rot_q       <= 4'd0;
            ok_q        <= 1'b0;
            field_q     <= 24'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            rot_q       <= rot_d;
            ok_q        <= ok_d;
            field_q     <= field_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign ok        = ok_q;
    assign field     = field_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed and random-round-trip bench for imm_encoder; expected values are
// hand-computed or derived from a local model of the extend decoder.
module tb_imm_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mode;
    logic [31:0] value;
    logic        out_valid;
    logic        out_ready;
    logic        ok;
    logic [23:0] field;

    int n_checks;
    int n_fail;

    imm_encoder #(.MAX_ROT(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .value     (value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ok        (ok),
        .field     (field)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] extend(input logic [23:0] f, input logic [1:0] m);
        logic [31:0] imm;
        logic [63:0] t;
        case (m)
            2'b00:   imm = {24'd0, f[7:0]};
            2'b01:   imm = {20'd0, f[11:0]};
            2'b10:   imm = {{6{f[23]}}, f, 2'b00};
            default: begin
                imm = {24'd0, f[7:0]};
                t   = {imm, imm} >> (2 * f[11:8]);
                imm = t[31:0];
            end
        endcase
        return imm;
    endfunction

    function automatic logic [23:0] trunc_field(input logic [31:0] v, input logic [1:0] m);
        case (m)
            2'b00:   return {16'd0, v[7:0]};
            2'b01:   return {12'd0, v[11:0]};
            default: return v[25:2];
        endcase
    endfunction

    // Issue one request from IDLE, wait (bounded) for the response, then accept it.
    task automatic do_req(input logic [1:0] m, input logic [31:0] v,
                          output logic o_ok, output logic [23:0] o_field, output int lat);
        mode     = m;
        value    = v;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        o_ok      = ok;
        o_field   = field;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL reset_ok: got %b expected 0", ok); end
        n_checks++; if (field !== 24'd0) begin n_fail++; $display("FAIL reset_field: got %h expected 000000", field); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_direct();
        logic [1:0]  vm  [8];
        logic [31:0] vv  [8];
        logic        eok [8];
        logic [23:0] ef  [8];
        logic        r_ok;
        logic [23:0] r_f;
        int          lat;
        vm[0] = 2'b00; vv[0] = 32'h0000_00AB; eok[0] = 1; ef[0] = 24'h0000AB;
        vm[1] = 2'b00; vv[1] = 32'h0000_0100; eok[1] = 0; ef[1] = 24'h000000;
        vm[2] = 2'b01; vv[2] = 32'h0000_0FFF; eok[2] = 1; ef[2] = 24'h000FFF;
        vm[3] = 2'b01; vv[3] = 32'h0000_1000; eok[3] = 0; ef[3] = 24'h000000;
        vm[4] = 2'b10; vv[4] = 32'hFFFF_FFF8; eok[4] = 1; ef[4] = 24'hFFFFFE;
        vm[5] = 2'b10; vv[5] = 32'h01FF_FFFC; eok[5] = 1; ef[5] = 24'h7FFFFF;
        vm[6] = 2'b10; vv[6] = 32'h0200_0000; eok[6] = 0; ef[6] = 24'h000000;
        vm[7] = 2'b10; vv[7] = 32'h0000_0006; eok[7] = 0; ef[7] = 24'h000000;
        for (int i = 0; i < 8; i++) begin
            do_req(vm[i], vv[i], r_ok, r_f, lat);
            n_checks++; if (r_ok !== eok[i]) begin n_fail++; $display("FAIL direct_ok[%0d]: got %b expected %b", i, r_ok, eok[i]); end
            n_checks++; if (r_f !== ef[i]) begin n_fail++; $display("FAIL direct_field[%0d]: got %h expected %h", i, r_f, ef[i]); end
            n_checks++; if (lat != 1) begin n_fail++; $display("FAIL direct_latency[%0d]: got %0d expected 1", i, lat); end
        end
        do_req(2'b10, 32'hFFFF_FFF8, r_ok, r_f, lat);
        n_checks++; if (extend(r_f, 2'b10) !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL br24_roundtrip: got %h expected FFFFFFF8", extend(r_f, 2'b10)); end
    endtask

    task automatic test_rot();
        logic [31:0] vv  [6];
        logic        eok [6];
        logic [23:0] ef  [6];
        int          elat[6];
        logic        r_ok;
        logic [23:0] r_f;
        int          lat;
        vv[0] = 32'hFF00_0000; eok[0] = 1; ef[0] = 24'h0004FF; elat[0] = 6;
        vv[1] = 32'h0000_0102; eok[1] = 0; ef[1] = 24'h000000; elat[1] = 17;
        vv[2] = 32'h0000_0000; eok[2] = 1; ef[2] = 24'h000000; elat[2] = 2;
        vv[3] = 32'h0000_00AB; eok[3] = 1; ef[3] = 24'h0000AB; elat[3] = 2;
        vv[4] = 32'h0000_03FC; eok[4] = 1; ef[4] = 24'h000FFF; elat[4] = 17;
        vv[5] = 32'hF000_000F; eok[5] = 1; ef[5] = 24'h0002FF; elat[5] = 4;
        for (int i = 0; i < 6; i++) begin
            do_req(2'b11, vv[i], r_ok, r_f, lat);
            n_checks++; if (r_ok !== eok[i]) begin n_fail++; $display("FAIL rot_ok[%0d]: got %b expected %b", i, r_ok, eok[i]); end
            n_checks++; if (r_f !== ef[i]) begin n_fail++; $display("FAIL rot_field[%0d]: got %h expected %h", i, r_f, ef[i]); end
            n_checks++; if (lat != elat[i]) begin n_fail++; $display("FAIL rot_latency[%0d]: got %0d expected %0d", i, lat, elat[i]); end
        end
    endtask

    task automatic test_backpressure();
        int          waitc;
        logic        r_ok;
        logic [23:0] r_f;
        int          lat;
        mode = 2'b11; value = 32'hFF00_0000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        waitc = 0;
        while (out_valid !== 1'b1 && waitc < 40) begin @(posedge clk); #1; waitc++; end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; mode = 2'b00; value = 32'h0000_0012;
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", c, out_valid); end
            n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_ok[%0d]: got %b expected 1", c, ok); end
            n_checks++; if (field !== 24'h0004FF) begin n_fail++; $display("FAIL bp_field[%0d]: got %h expected 0004FF", c, field); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", c, in_ready); end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
        do_req(2'b00, 32'h0000_0034, r_ok, r_f, lat);
        n_checks++; if (r_f !== 24'h000034 || r_ok !== 1'b1) begin n_fail++; $display("FAIL bp_next_req: got ok=%b field=%h expected ok=1 field=000034", r_ok, r_f); end
    endtask

    task automatic test_reset_search();
        logic        r_ok;
        logic [23:0] r_f;
        int          lat;
        mode = 2'b11; value = 32'h0000_0102; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rs_busy: got in_ready=%b expected 0", in_ready); end
        reset = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rs_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rs_out_valid: got %b expected 0", out_valid); end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rs_no_response: got out_valid=%b expected 0", out_valid); end
        do_req(2'b01, 32'h0000_0123, r_ok, r_f, lat);
        n_checks++; if (r_ok !== 1'b1 || r_f !== 24'h000123 || lat != 1) begin
            n_fail++; $display("FAIL rs_next_req: got ok=%b field=%h lat=%0d expected ok=1 field=000123 lat=1", r_ok, r_f, lat);
        end
    endtask

    task automatic test_roundtrip();
        logic [1:0]  m;
        logic [31:0] v;
        logic [31:0] r;
        logic        r_ok;
        logic [23:0] r_f;
        int          lat;
        for (int i = 0; i < 1000; i++) begin
            m = 2'(i % 3);
            r = $urandom;
            case ((i / 3) % 4)
                0:       v = r;
                1:       v = 32'($urandom_range(0, 4095));
                2:       v = {{6{r[25]}}, r[25:2], 2'b00};
                default: v = r & 32'h03FF_FFFF;
            endcase
            do_req(m, v, r_ok, r_f, lat);
            n_checks++; if (lat != 1) begin n_fail++; $display("FAIL rt_latency: mode=%0d value=%h got %0d expected 1", m, v, lat); end
            if (r_ok === 1'b1) begin
                n_checks++; if (extend(r_f, m) !== v) begin n_fail++; $display("FAIL rt_extend: mode=%0d value=%h field=%h got %h", m, v, r_f, extend(r_f, m)); end
                n_checks++; if (r_f !== trunc_field(v, m)) begin n_fail++; $display("FAIL rt_field: mode=%0d value=%h got %h expected %h", m, v, r_f, trunc_field(v, m)); end
            end else begin
                n_checks++; if (extend(trunc_field(v, m), m) === v) begin n_fail++; $display("FAIL rt_rejected: mode=%0d value=%h got ok=%b expected 1", m, v, r_ok); end
                n_checks++; if (r_f !== 24'd0) begin n_fail++; $display("FAIL rt_zero_field: mode=%0d value=%h got %h expected 000000", m, v, r_f); end
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mode      = 2'b00;
        value     = 32'd0;
        test_reset();
        test_direct();
        test_rot();
        test_backpressure();
        test_reset_search();
        test_roundtrip();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Immediate-field encoder: the inverse of the `extend` immediate decoder. It takes a 32-bit constant or byte offset plus an ImmSrc-style mode, range-checks it, and returns the instruction bit field that `extend` would expand back to the same value. Mode 2'b11 adds the rotated data-processing immediate (rot4:imm8), found by a sequential rotation search. The block sits in the instruction loader/assembler-support path and uses a valid/ready request/response handshake.

## Interface
- `MAX_ROT`, 15, last rotation index tried in mode 2'b11 (rotation amount = 2*rot).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  block can accept a request; high only in IDLE.
- `mode`  in  2  00 imm8, 01 imm12, 10 branch imm24, 11 rotated imm8.
- `value`  in  32  constant (modes 00/01/11) or byte offset relative to PC+8 (mode 10).
- `out_valid`  out  1  result present; held until accepted.
- `out_ready`  in  1  consumer accepts the result.
- `ok`  out  1  value is encodable in the requested mode.
- `field`  out  24  Instr[23:0] contribution; unused bits are 0.

## Operation
- States: IDLE, SEARCH, RESP.
- IDLE: `in_ready`=1. On `in_valid`: latch `mode` and `value`.
  - Modes 00/01/10: compute the result, register it, and go to RESP.
  - Mode 11: clear `rot`, go to SEARCH.
- Mode 00: `ok` = (value[31:8]==0); `field[7:0]` = value[7:0].
- Mode 01: `ok` = (value[31:12]==0); `field[11:0]` = value[11:0].
- Mode 10: `ok` = (value[1:0]==0) and value[31:26] all equal value[25]; `field` = value[25:2].
- Mode 11, SEARCH, one rotation per cycle:
  - `cand` = value rotated left by 2*rot.
  - Hit when cand[31:8]==0: `ok`=1, `field[11:8]`=rot, `field[7:0]`=cand[7:0], go to RESP.
  - Miss with rot<MAX_ROT: rot+1.
  - Miss with rot==MAX_ROT: `ok`=0, go to RESP.
  - The lowest hitting rot wins. value 0 hits at rot 0.
- Whenever `ok`=0, `field` = 0.
- RESP: `out_valid`=1, with `ok` and `field` stable. When `out_ready` is high, return to IDLE. No back-to-back accept in the same cycle.
- `in_valid` is ignored outside IDLE.
- `reset` mid-operation aborts the request. No response is produced.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `ok`=0, `field`=0, rot=0.
- Let E0 be the acceptance edge.
- Modes 00/01/10: `out_valid` is high from E0. Latency 1 cycle.
- Mode 11: rot k is tested in the cycle after edge E0+k. A hit at rot k gives `out_valid` from edge E0+k+1 (latency k+2). A full miss gives latency MAX_ROT+2 = 17.
- Response-to-next-request: the edge where `out_valid`&&`out_ready` returns to IDLE. The next acceptance is at the earliest one edge later.
- All outputs are registered except `in_ready`, which is decoded from the state register.

## Structure
- Shared package `imm_pkg` holds:
  - Mode constants: IMM_DP8=2'b00, IMM_MEM12=2'b01, IMM_BR24=2'b10, IMM_ROT=2'b11. `extend` uses the same constants.
  - The state enum.
- One combinational sub-module, `imm_rot_check`:
  - Inputs: value, rot.
  - Outputs: hit, imm8.
  - Instantiated once; it is reused across SEARCH cycles.

## Test plan
- Mode 00, value 0x000000AB -> ok=1, field=0x0000AB, latency 1. value 0x00000100 -> ok=0, field=0.
- Mode 10, value 0xFFFFFFF8 -> field=0xFFFFFE, and `extend` round-trips it to 0xFFFFFFF8. value 0x01FFFFFC -> field=0x7FFFFF. value 0x02000000 -> ok=0. value 0x00000006 -> ok=0 (misaligned).
- Mode 11, value 0xFF000000 -> ok=1, field=0x0004FF, out_valid 6 cycles after accept. value 0x00000102 -> ok=0 after 17 cycles.
- Backpressure: hold `out_ready`=0 for 5 cycles. `out_valid`, `ok` and `field` must stay stable, `in_ready`=0, and a new `in_valid` is ignored.
- Reset asserted during SEARCH (mode 11, 0x00000102, cycle 5) -> immediately IDLE, `out_valid`=0, `in_ready`=1. The next request completes normally.
- Random round-trip: 1000 values in modes 00/01/10. Wherever ok=1, `extend(field, mode)` equals value. Wherever ok=0, no encoding exists.
